line_buffer_window: RTL and testbench
=====================================

// Module: line_buffer_window
// PURPOSE
//  Parametrised multi-line buffer for the HOG front end. Accepts a raster pixel stream.
//  Emits one vertical column of KERNEL_HEIGHT pixels per accepted input pixel, with row/column
//  border flags and frame markers. Feeds the kernel window shift registers of the gradient stage.
//  Supports runtime image width, multiple packed channels and full ready/valid backpressure.
// PARAMETERS
//  DATA_WIDTH    8    bits per channel sample
//  CHANNELS      1    channels packed per pixel, channel 0 in LSBs
//  MAX_WIDTH     1024 max line length; sets line memory depth
//  KERNEL_HEIGHT 3    rows per output column (KERNEL_HEIGHT-1 line memories)
//  KERNEL_WIDTH  3    window width; used only for column border flag
//  ROW_W         16   width of row/col counters and img_width/img_height ports
// PORTS
//  clk        in  1                          clock
//  rst        in  1                          reset, asynchronous, active-high
//  img_width  in  ROW_W                      active line length, sampled on accepted s_sof
//  img_height in  ROW_W                      active line count, sampled on accepted s_sof
//  s_data     in  DATA_WIDTH*CHANNELS        input pixel
//  s_sof      in  1                          first pixel of frame, qualified by s_valid
//  s_valid    in  1                          input valid
//  s_ready    out 1                          input ready
//  m_data     out DATA_WIDTH*CHANNELS*KERNEL_HEIGHT  column; slice 0 = oldest row, top = current row
//  m_valid    out 1                          output valid
//  m_ready    in  1                          output ready
//  m_col_border out 1                        column index < KERNEL_WIDTH-1 (window incomplete)
//  m_sof      out 1                          first output column of the frame
//  m_eol      out 1                          last column of a line
//  m_eof      out 1                          last column of the frame
// BEHAVIOUR
//  - Reset: s_ready=1. m_valid=0. All m_* flags=0. Counters=0. Latched width/height=MAX_WIDTH/KERNEL_HEIGHT.
//    m_data is don't-care. Reset mid-frame discards all partial lines.
//  - Transfer: in_fire = s_valid&s_ready, out_fire = m_valid&m_ready.
//    s_ready = ~m_valid | m_ready (single output stage, no bubble at full throughput).
//  - Line memories are indexed by the col counter. On in_fire, each line memory k reads address col and
//    forwards the read word into line memory k+1 at address col. The input pixel is written into line 0.
//    Read-before-write is required on the same address.
//  - Latency: 1 cycle from in_fire to m_valid (BRAM read register). Memory enable = in_fire only.
//    Stalls freeze the memory outputs and the m_* registers.
//  - Counters: col wraps at width-1 to 0 and row increments. row wraps at height-1 to 0.
//    An accepted s_sof forces col=row=0 for that pixel, regardless of the current counts.
//  - m_valid is set on in_fire only when row >= KERNEL_HEIGHT-1. Earlier rows prime the memories.
//    They produce no output and are always accepted while s_ready=1.
//  - Flags are registered alongside m_data from the input pixel's col/row:
//    m_col_border = col<KERNEL_WIDTH-1. m_sof = first emitted column (row==KERNEL_HEIGHT-1, col==0).
//    m_eol = col==width-1. m_eof = m_eol & row==height-1.
//  - Width rules: latched img_width is clamped to [KERNEL_WIDTH, MAX_WIDTH].
//    Latched img_height is clamped to >= KERNEL_HEIGHT.
//  - Frame boundary: after the eof pixel, the next frame re-primes. Stale lines from the previous frame
//    are never emitted as valid, because row restarts at 0.
//  - Simultaneous out_fire and in_fire in the same cycle: the new column replaces the old one. m_valid stays 1.
// STRUCTURE
//  - Package hog_pkg: clog2-based ADDR_W, the pixel-width and column-width localparams, and the flag bit order.
//  - Sub-module line_mem: simple dual-port BRAM, DATA_WIDTH*CHANNELS x MAX_WIDTH, 1-cycle read, read-first.
//    Instantiated KERNEL_HEIGHT-1 times in a generate chain.
//  - Top level holds the counters, the width/height latch, the output register and the handshake.
// TESTING
//  1 Reset then W=8,H=4,KH=3: stream pixel=16*row+col with m_ready=1.
//    No m_valid during rows 0-1. The first m_data column is {0x20,0x10,0x00}. 16 columns are emitted.
//  2 Same stream: m_col_border=1 exactly at cols 0,1. m_eol at col 7. m_eof once, on pixel 0x37. m_sof once.
//  3 Random m_ready stalls (50%): output sequence identical to test 1.
//    s_ready=0 whenever m_valid&~m_ready. No data lost or duplicated.
//  4 Back-to-back frames with W=8 then W=5 (s_sof on each): second frame emits columns of width 5.
//    No column containing frame-1 data is emitted.
//  5 CHANNELS=3, img_width=2000 > MAX_WIDTH=1024: width is clamped to 1024. The channels stay independent in m_data.
//  6 Assert rst mid row 2: m_valid drops asynchronously. A new frame after reset matches test 1 exactly.

Source files
------------

// File: rtl/hog_pkg.sv
// Shared types and helpers for the HOG front-end line buffer.
package hog_pkg;

    localparam int DEF_DATA_WIDTH    = 8;
    localparam int DEF_CHANNELS      = 1;
    localparam int DEF_MAX_WIDTH     = 1024;
    localparam int DEF_KERNEL_HEIGHT = 3;
    localparam int DEF_KERNEL_WIDTH  = 3;
    localparam int DEF_ROW_W         = 16;

    // Output flag bundle; the field order fixes the bit order, colBorder in bit 0.
    typedef struct packed {
        logic eof;
        logic eol;
        logic sof;
        logic colBorder;
    } flags_t;

    // Line memory address width for a given depth, never narrower than one bit.
    function automatic int addrWidth(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Width of one packed pixel holding all channels.
    function automatic int pixelWidth(input int dataWidth, input int channels);
        return dataWidth * channels;
    endfunction

endpackage

// File: rtl/line_mem.sv
// One line of pixel storage: simple dual-port RAM with a registered, read-first read port.
module line_mem #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              i_rd_en,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [WIDTH-1:0]  o_rd_data,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [WIDTH-1:0]  i_wr_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdData;

    // Read returns the old word when the write hits the same address; read data holds while disabled.
    always_ff @(posedge clk) begin
        if (i_rd_en) begin
            r_rdData <= r_mem[i_rd_addr];
        end
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_rdData;

endmodule

// File: rtl/line_buffer_window.sv
// Multi-line buffer: turns a raster pixel stream into vertical KERNEL_HEIGHT-pixel columns
// with border and frame flags, under full ready/valid backpressure.
module line_buffer_window
    import hog_pkg::*;
#(
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int CHANNELS      = DEF_CHANNELS,
    parameter int MAX_WIDTH     = DEF_MAX_WIDTH,
    parameter int KERNEL_HEIGHT = DEF_KERNEL_HEIGHT,
    parameter int KERNEL_WIDTH  = DEF_KERNEL_WIDTH,
    parameter int ROW_W         = DEF_ROW_W
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic [ROW_W-1:0]                            i_img_width,
    input  logic [ROW_W-1:0]                            i_img_height,
    input  logic [DATA_WIDTH*CHANNELS-1:0]              i_s_data,
    input  logic                                        i_s_sof,
    input  logic                                        i_s_valid,
    output logic                                        o_s_ready,
    output logic [DATA_WIDTH*CHANNELS*KERNEL_HEIGHT-1:0] o_m_data,
    output logic                                        o_m_valid,
    input  logic                                        i_m_ready,
    output logic                                        o_m_col_border,
    output logic                                        o_m_sof,
    output logic                                        o_m_eol,
    output logic                                        o_m_eof
);

    localparam int PIX_W  = pixelWidth(DATA_WIDTH, CHANNELS);
    localparam int ADDR_W = addrWidth(MAX_WIDTH);
    localparam int NMEM   = KERNEL_HEIGHT - 1;

    localparam logic [ROW_W-1:0] ONE_C    = ROW_W'(1);
    localparam logic [ROW_W-1:0] KW_C     = ROW_W'(KERNEL_WIDTH);
    localparam logic [ROW_W-1:0] KWM1_C   = ROW_W'(KERNEL_WIDTH - 1);
    localparam logic [ROW_W-1:0] KH_C     = ROW_W'(KERNEL_HEIGHT);
    localparam logic [ROW_W-1:0] KHM1_C   = ROW_W'(KERNEL_HEIGHT - 1);
    localparam logic [ROW_W-1:0] MAXW_C   = ROW_W'(MAX_WIDTH);

    logic [ROW_W-1:0]  r_col;
    logic [ROW_W-1:0]  r_row;
    logic [ROW_W-1:0]  r_width;
    logic [ROW_W-1:0]  r_height;
    logic [PIX_W-1:0]  r_pix;
    logic              r_valid;
    flags_t            r_flags;
    logic              r_fwdPending;
    logic [ADDR_W-1:0] r_fwdAddr;

    logic              w_inFire;
    logic              w_outFire;
    logic              w_sofTake;
    logic [ROW_W-1:0]  w_clampWidth;
    logic [ROW_W-1:0]  w_clampHeight;
    logic [ROW_W-1:0]  w_effCol;
    logic [ROW_W-1:0]  w_effRow;
    logic [ROW_W-1:0]  w_effWidth;
    logic [ROW_W-1:0]  w_effHeight;
    logic              w_lastCol;
    logic              w_lastRow;
    logic [ROW_W-1:0]  w_nextCol;
    logic [ROW_W-1:0]  w_nextRow;
    flags_t            w_flags;
    logic [ADDR_W-1:0] w_addr;
    logic [PIX_W-1:0]  w_memRd [NMEM];

    assign o_s_ready = ~r_valid | i_m_ready;
    assign w_inFire  = i_s_valid & o_s_ready;
    assign w_outFire = r_valid & i_m_ready;
    assign w_sofTake = i_s_valid & i_s_sof;
    assign w_addr    = w_effCol[ADDR_W-1:0];

    // Position of the incoming pixel: an sof pixel restarts at (0,0) with freshly clamped geometry.
    always_comb begin
        w_clampWidth = i_img_width;
        if (i_img_width < KW_C) begin
            w_clampWidth = KW_C;
        end else if (i_img_width > MAXW_C) begin
            w_clampWidth = MAXW_C;
        end
        w_clampHeight = (i_img_height < KH_C) ? KH_C : i_img_height;

        w_effCol    = w_sofTake ? '0 : r_col;
        w_effRow    = w_sofTake ? '0 : r_row;
        w_effWidth  = w_sofTake ? w_clampWidth : r_width;
        w_effHeight = w_sofTake ? w_clampHeight : r_height;

        w_lastCol = (w_effCol == (w_effWidth - ONE_C));
        w_lastRow = (w_effRow == (w_effHeight - ONE_C));
        w_nextCol = w_lastCol ? '0 : (w_effCol + ONE_C);
        w_nextRow = w_effRow;
        if (w_lastCol) begin
            w_nextRow = w_lastRow ? '0 : (w_effRow + ONE_C);
        end

        w_flags           = '0;
        w_flags.colBorder = (w_effCol < KWM1_C);
        w_flags.sof       = (w_effRow == KHM1_C) && (w_effCol == '0);
        w_flags.eol       = w_lastCol;
        w_flags.eof       = w_lastCol && w_lastRow;
    end

    // Raster counters and the per-frame geometry latch advance once per accepted pixel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_col    <= '0;
            r_row    <= '0;
            r_width  <= MAXW_C;
            r_height <= KH_C;
        end else if (w_inFire) begin
            r_col    <= w_nextCol;
            r_row    <= w_nextRow;
            r_width  <= w_effWidth;
            r_height <= w_effHeight;
        end
    end

    // Output stage: a new column replaces the current one; priming rows clear valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_flags <= '0;
            r_pix   <= '0;
        end else if (w_inFire) begin
            r_valid <= (w_effRow >= KHM1_C);
            r_flags <= w_flags;
            r_pix   <= i_s_data;
        end else if (w_outFire) begin
            r_valid <= 1'b0;
        end
    end

    // Each line's read word lands in its read register one cycle late, so the shift into the next
    // line is written on the following accepted pixel at the remembered address.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fwdPending <= 1'b0;
            r_fwdAddr    <= '0;
        end else if (w_inFire) begin
            r_fwdPending <= 1'b1;
            r_fwdAddr    <= w_addr;
        end
    end

    generate
        for (genvar k = 0; k < NMEM; k++) begin : g_line
            logic              w_wrEn;
            logic [ADDR_W-1:0] w_wrAddr;
            logic [PIX_W-1:0]  w_wrData;

            if (k == 0) begin : g_head
                assign w_wrEn   = w_inFire;
                assign w_wrAddr = w_addr;
                assign w_wrData = i_s_data;
            end else begin : g_tail
                assign w_wrEn   = w_inFire & r_fwdPending;
                assign w_wrAddr = r_fwdAddr;
                assign w_wrData = w_memRd[k-1];
            end

            line_mem #(
                .WIDTH  (PIX_W),
                .DEPTH  (MAX_WIDTH),
                .ADDR_W (ADDR_W)
            ) u_mem (
                .clk       (clk),
                .i_rd_en   (w_inFire),
                .i_rd_addr (w_addr),
                .o_rd_data (w_memRd[k]),
                .i_wr_en   (w_wrEn),
                .i_wr_addr (w_wrAddr),
                .i_wr_data (w_wrData)
            );

            assign o_m_data[(NMEM-1-k)*PIX_W +: PIX_W] = w_memRd[k];
        end
    endgenerate

    assign o_m_data[NMEM*PIX_W +: PIX_W] = r_pix;
    assign o_m_valid      = r_valid;
    assign o_m_col_border = r_flags.colBorder;
    assign o_m_sof        = r_flags.sof;
    assign o_m_eol        = r_flags.eol;
    assign o_m_eof        = r_flags.eof;

endmodule

// File: tb/tb_line_buffer_window.sv
// Self-checking bench for line_buffer_window: a table-driven reference frame, randomized frames
// scored against a frame-array model, and hand-written reset and clamp sequences.
module tb_line_buffer_window;

    localparam int DW     = 8;
    localparam int CH     = 3;
    localparam int MAXW   = 1024;
    localparam int KH     = 3;
    localparam int KW     = 3;
    localparam int RW     = 16;
    localparam int PW     = DW * CH;
    localparam int MW     = PW * KH;
    localparam int STRIDE = 4096;

    typedef struct packed {
        logic [MW-1:0] data;
        logic          colBorder;
        logic          sof;
        logic          eol;
        logic          eof;
    } column_t;

    typedef struct {
        logic [PW-1:0] pix;
        logic          sof;
        logic          expValid;
        column_t       expCol;
    } vector_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [RW-1:0] imgWidth;
    logic [RW-1:0] imgHeight;
    logic [PW-1:0] sData;
    logic          sSof;
    logic          sValid;
    logic          sReady;
    logic [MW-1:0] mData;
    logic          mValid;
    logic          mReady;
    logic          mColBorder;
    logic          mSof;
    logic          mEol;
    logic          mEof;

    column_t       expQ[$];
    logic [PW-1:0] frame [int];
    int            modelCol;
    int            modelRow;
    int            modelWidth;
    int            modelHeight;
    int            nVec = 0;
    int            nFail = 0;
    int            emitted = 0;
    int            sofSeen = 0;
    int            eofSeen = 0;
    bit            randReady = 1'b0;

    line_buffer_window #(
        .DATA_WIDTH    (DW),
        .CHANNELS      (CH),
        .MAX_WIDTH     (MAXW),
        .KERNEL_HEIGHT (KH),
        .KERNEL_WIDTH  (KW),
        .ROW_W         (RW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .i_img_width    (imgWidth),
        .i_img_height   (imgHeight),
        .i_s_data       (sData),
        .i_s_sof        (sSof),
        .i_s_valid      (sValid),
        .o_s_ready      (sReady),
        .o_m_data       (mData),
        .o_m_valid      (mValid),
        .i_m_ready      (mReady),
        .o_m_col_border (mColBorder),
        .o_m_sof        (mSof),
        .o_m_eol        (mEol),
        .o_m_eof        (mEof)
    );

    // Free-running 100 MHz clock.
    always #5 clk = ~clk;

    // Hard stop so a wedged handshake can never hang the run.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got still running, want finished");
        $fatal(1, "[TB] time limit reached");
    end

    // Three distinct channels per pixel so any channel mixing shows up in the data compare.
    function automatic logic [PW-1:0] mkPix(input int v);
        logic [7:0] b;
        b = v[7:0];
        return {b ^ 8'h3C, ~b, b};
    endfunction

    // Reference model: remember every pixel of the current frame by (row, col) and, once enough
    // rows exist, expect the column made of the same col from the last KH rows.
    function automatic void modelAccept(input logic [PW-1:0] px, input logic sof);
        column_t e;
        if (sof) begin
            modelCol    = 0;
            modelRow    = 0;
            modelWidth  = int'(imgWidth);
            if (modelWidth < KW) modelWidth = KW;
            if (modelWidth > MAXW) modelWidth = MAXW;
            modelHeight = int'(imgHeight);
            if (modelHeight < KH) modelHeight = KH;
            frame.delete();
        end
        frame[modelRow * STRIDE + modelCol] = px;
        if (modelRow >= KH - 1) begin
            e.data = '0;
            for (int k = 0; k < KH; k++) begin
                e.data[k*PW +: PW] = frame[(modelRow - (KH - 1) + k) * STRIDE + modelCol];
            end
            e.colBorder = (modelCol < KW - 1);
            e.sof       = (modelRow == KH - 1) && (modelCol == 0);
            e.eol       = (modelCol == modelWidth - 1);
            e.eof       = e.eol && (modelRow == modelHeight - 1);
            expQ.push_back(e);
        end
        if (modelCol == modelWidth - 1) begin
            modelCol = 0;
            modelRow = (modelRow == modelHeight - 1) ? 0 : modelRow + 1;
        end else begin
            modelCol = modelCol + 1;
        end
    endfunction

    // Scoreboard on the falling edge: score each output transfer, police backpressure, then
    // feed the accepted input to the model; reset wipes the model like it wipes the DUT.
    always @(negedge clk) begin
        column_t got;
        column_t want;
        if (rst) begin
            expQ.delete();
            frame.delete();
            modelCol    = 0;
            modelRow    = 0;
            modelWidth  = MAXW;
            modelHeight = KH;
        end else begin
            if (mValid && !mReady) begin
                nVec++;
                if (sReady !== 1'b0) begin
                    nFail++;
                    $display("[TB] FAIL sReadyStall: got %b want 0", sReady);
                end
            end
            if (mValid && mReady) begin
                emitted++;
                if (mSof) sofSeen++;
                if (mEof) eofSeen++;
                nVec++;
                got = {mData, mColBorder, mSof, mEol, mEof};
                if (expQ.size() == 0) begin
                    nFail++;
                    $display("[TB] FAIL extraColumn: got %h want no column", got.data);
                end else begin
                    want = expQ.pop_front();
                    if (got !== want) begin
                        nFail++;
                        $display("[TB] FAIL column: got %h b%b s%b l%b f%b want %h b%b s%b l%b f%b",
                                 got.data, got.colBorder, got.sof, got.eol, got.eof,
                                 want.data, want.colBorder, want.sof, want.eol, want.eof);
                    end
                end
            end
            if (sValid && sReady) begin
                modelAccept(sData, sSof);
            end
        end
    end

    task automatic checkOutput(input string name, input logic [MW-1:0] got, input logic [MW-1:0] want);
        nVec++;
        if (got !== want) begin
            nFail++;
            $display("[TB] FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic checkCount(input string name, input int got, input int want);
        nVec++;
        if (got != want) begin
            nFail++;
            $display("[TB] FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    // Offer one pixel (after optional idle gaps) and hold it until accepted; returns at posedge+1.
    task automatic applyStimulus(input logic [PW-1:0] px, input logic sof, input int gapPct);
        bit done;
        int guard;
        done  = 1'b0;
        guard = 0;
        while (gapPct > 0 && $urandom_range(0, 99) < gapPct) begin
            sValid = 1'b0;
            if (randReady) mReady = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
        end
        sValid = 1'b1;
        sData  = px;
        sSof   = sof;
        while (!done) begin
            if (randReady) mReady = 1'($urandom_range(0, 1));
            @(negedge clk);
            done = sReady;
            @(posedge clk);
            #1;
            if (!done) begin
                guard++;
                if (guard > 200) begin
                    checkCount("acceptTimeout", guard, 0);
                    done = 1'b1;
                end
            end
        end
        sValid = 1'b0;
        sSof   = 1'b0;
    endtask

    // Random-content frame (or partial frame) starting with sof.
    task automatic sendFrame(input int w, input int h, input int nPix, input int gapPct);
        imgWidth  = RW'(w);
        imgHeight = RW'(h);
        for (int i = 0; i < nPix; i++) begin
            applyStimulus(PW'($urandom), (i == 0), gapPct);
        end
    endtask

    // Let the output drain and confirm nothing is left owed or still pending.
    task automatic drain();
        randReady = 1'b0;
        sValid    = 1'b0;
        sSof      = 1'b0;
        mReady    = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkCount("queueEmpty", expQ.size(), 0);
        checkCount("idleValid", int'(mValid), 0);
    endtask

    // 8x4 frame of pixel 16*row+col with m_ready held high: every cycle's output is checked
    // against a table computed from the window rules, then column/sof/eof totals.
    task automatic runTable();
        vector_t tbl [32];
        int      e0;
        int      s0;
        int      f0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 8; c++) begin
                int i;
                i = r * 8 + c;
                tbl[i].pix             = mkPix(16 * r + c);
                tbl[i].sof             = (i == 0);
                tbl[i].expValid        = (r >= 2);
                tbl[i].expCol.data     = (r >= 2) ? {mkPix(16 * r + c), mkPix(16 * (r - 1) + c), mkPix(16 * (r - 2) + c)} : '0;
                tbl[i].expCol.colBorder = (c < 2);
                tbl[i].expCol.sof      = (r == 2) && (c == 0);
                tbl[i].expCol.eol      = (c == 7);
                tbl[i].expCol.eof      = (c == 7) && (r == 3);
            end
        end
        imgWidth  = RW'(8);
        imgHeight = RW'(4);
        mReady    = 1'b1;
        randReady = 1'b0;
        e0 = emitted;
        s0 = sofSeen;
        f0 = eofSeen;
        for (int i = 0; i < 32; i++) begin
            applyStimulus(tbl[i].pix, tbl[i].sof, 0);
            checkCount("tblValid", int'(mValid), int'(tbl[i].expValid));
            if (tbl[i].expValid) begin
                checkOutput("tblData", mData, tbl[i].expCol.data);
                checkOutput("tblFlags", MW'({mColBorder, mSof, mEol, mEof}),
                            MW'({tbl[i].expCol.colBorder, tbl[i].expCol.sof, tbl[i].expCol.eol, tbl[i].expCol.eof}));
            end
            if (i == 16) begin
                checkOutput("firstColumnCh0", MW'({mData[55:48], mData[31:24], mData[7:0]}), MW'(24'h201000));
            end
        end
        drain();
        checkCount("tblColumns", emitted - e0, 16);
        checkCount("tblSofCount", sofSeen - s0, 1);
        checkCount("tblEofCount", eofSeen - f0, 1);
    endtask

    initial begin
        int e0;
        int f0;
        rst       = 1'b1;
        sValid    = 1'b0;
        sSof      = 1'b0;
        sData     = '0;
        mReady    = 1'b1;
        imgWidth  = RW'(8);
        imgHeight = RW'(4);
        repeat (3) @(posedge clk);
        #1;
        checkCount("resetSReady", int'(sReady), 1);
        checkCount("resetMValid", int'(mValid), 0);
        checkCount("resetFlags", int'({mColBorder, mSof, mEol, mEof}), 0);
        rst = 1'b0;

        $display("[TB] reference 8x4 frame");
        runTable();

        $display("[TB] same frame under random stalls and gaps");
        randReady = 1'b1;
        e0 = emitted;
        imgWidth  = RW'(8);
        imgHeight = RW'(4);
        for (int i = 0; i < 32; i++) begin
            applyStimulus(mkPix(16 * (i / 8) + (i % 8)), (i == 0), 25);
        end
        drain();
        checkCount("stallColumns", emitted - e0, 16);

        $display("[TB] back-to-back frames, width change and an aborted frame");
        e0 = emitted;
        f0 = eofSeen;
        sendFrame(8, 4, 32, 0);
        sendFrame(5, 4, 20, 0);
        sendFrame(8, 4, 10, 0);
        sendFrame(5, 4, 20, 0);
        drain();
        checkCount("b2bColumns", emitted - e0, 36);
        checkCount("b2bEofCount", eofSeen - f0, 3);

        $display("[TB] width clamps: 2000 to 1024, 1x1 to 3x3");
        e0 = emitted;
        f0 = eofSeen;
        sendFrame(2000, 3, MAXW * 3, 0);
        drain();
        checkCount("wideColumns", emitted - e0, MAXW);
        checkCount("wideEofCount", eofSeen - f0, 1);
        e0 = emitted;
        sendFrame(1, 1, 9, 0);
        drain();
        checkCount("tinyColumns", emitted - e0, 3);

        $display("[TB] reset in the middle of row 2");
        imgWidth  = RW'(8);
        imgHeight = RW'(4);
        for (int i = 0; i < 20; i++) begin
            applyStimulus(mkPix(16 * (i / 8) + (i % 8)), (i == 0), 0);
        end
        checkCount("preResetValid", int'(mValid), 1);
        rst = 1'b1;
        #1;
        checkCount("asyncResetValid", int'(mValid), 0);
        checkCount("asyncResetReady", int'(sReady), 1);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        runTable();

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
        $finish;
    end

endmodule
